// File: rtl/snn_pkg.sv
// Shared definitions for the synaptic accumulator slice.
// Holds the default parameter widths and the scan controller state type.
package snn_pkg;

  localparam int DEF_ID_WIDTH     = 4;
  localparam int DEF_WEIGHT_WIDTH = 4;
  localparam int DEF_POT_WIDTH    = 8;
  localparam int DEF_THRESHOLD    = 64;
  localparam int DEF_LEAK         = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/pot_regfile.sv
// Membrane potential storage: 2^Addr_Width words of Data_Width bits.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear of every word (has priority over writes)
//   we    - write enable for the single write port
//   waddr - write address
//   wdata - write data
//   raddr - combinational read address
//   rdata - combinational read data
module pot_regfile
  import snn_pkg::*;
#(
  parameter int Addr_Width = DEF_ID_WIDTH,
  parameter int Data_Width = DEF_POT_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [Addr_Width-1:0] waddr,
  input  logic [Data_Width-1:0] wdata,
  input  logic [Addr_Width-1:0] raddr,
  output logic [Data_Width-1:0] rdata
);

  localparam int Depth = 1 << Addr_Width;

  logic [Data_Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_accum.sv
// Synaptic accumulator with leaky integrate-and-fire scan.
// Weights from the lookup stage are added (saturating) into the target
// neuron's potential while idle. An end-of-timestep pulse starts a scan that
// visits one neuron per cycle, leaking it toward zero or emitting a spike
// with a valid/ready handshake and clearing it.
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   Valid_In    - a weight is presented on DstID_In/Weight_In
//   DstID_In    - target neuron index
//   Weight_In   - signed synaptic weight
//   Step_In     - end-of-timestep pulse, starts a scan
//   Spike_Ready - downstream accepts the presented spike
//   Spike_Valid - a spike is presented
//   Spike_ID    - index of the firing neuron
//   Busy        - scan in progress, Valid_In/Step_In are dropped
//
// state   | meaning
// IDLE    | accumulating weights, waiting for Step_In
// SCAN    | visiting neuron idx: fire check, else leak and advance
// EMIT    | spike for neuron idx presented, waiting for Spike_Ready
module syn_accum
  import snn_pkg::*;
#(
  parameter int ID_Width     = DEF_ID_WIDTH,
  parameter int Weight_Width = DEF_WEIGHT_WIDTH,
  parameter int Pot_Width    = DEF_POT_WIDTH,
  parameter int Threshold    = DEF_THRESHOLD,
  parameter int Leak         = DEF_LEAK
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Valid_In,
  input  logic [ID_Width-1:0]            DstID_In,
  input  logic signed [Weight_Width-1:0] Weight_In,
  input  logic                           Step_In,
  input  logic                           Spike_Ready,
  output logic                           Spike_Valid,
  output logic [ID_Width-1:0]            Spike_ID,
  output logic                           Busy
);

  // One guard bit so sums and compares never overflow before saturation.
  localparam int Ext_Width = Pot_Width + 1;
  localparam logic signed [Ext_Width-1:0] Thr_Ext  = Ext_Width'(Threshold);
  localparam logic signed [Ext_Width-1:0] Leak_Ext = Ext_Width'(Leak);

  state_t              state, state_nx;
  logic [ID_Width-1:0] idx, idx_nx;
  logic                spike_valid, spike_valid_nx;
  logic [ID_Width-1:0] spike_id, spike_id_nx;

  logic [ID_Width-1:0]  addr;
  logic                 we;
  logic [Pot_Width-1:0] wdata;
  logic [Pot_Width-1:0] pot_rd;

  logic signed [Ext_Width-1:0] pot_ext, w_ext, sum;
  logic [Pot_Width-1:0]        sat_sum;
  logic [Pot_Width-1:0]        leaked;
  logic                        fire;
  logic                        last;

  pot_regfile #(
    .Addr_Width (ID_Width),
    .Data_Width (Pot_Width)
  ) u_pot (
    .clk   (clk),
    .clr   (rst),
    .we    (we),
    .waddr (addr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (pot_rd)
  );

  assign pot_ext = {pot_rd[Pot_Width-1], pot_rd};
  assign w_ext   = Ext_Width'(Weight_In);
  assign sum     = pot_ext + w_ext;
  assign fire    = (pot_ext >= Thr_Ext);
  assign last    = &idx;

  // Guard bit disagreeing with the sign bit means the sum left the range.
  always_comb begin
    sat_sum = sum[Pot_Width-1:0];
    if (sum[Pot_Width] != sum[Pot_Width-1]) begin
      sat_sum = sum[Pot_Width] ? {1'b1, {(Pot_Width-1){1'b0}}}
                               : {1'b0, {(Pot_Width-1){1'b1}}};
    end
  end

  // Leak toward zero, clamping at zero rather than crossing it.
  always_comb begin
    leaked = '0;
    if (pot_ext > Leak_Ext) begin
      leaked = Pot_Width'(pot_ext - Leak_Ext);
    end else if (pot_ext < -Leak_Ext) begin
      leaked = Pot_Width'(pot_ext + Leak_Ext);
    end
  end

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    spike_valid_nx = spike_valid;
    spike_id_nx    = spike_id;
    addr           = idx;
    we             = 1'b0;
    wdata          = '0;
    case (state)
      ST_IDLE: begin
        addr = DstID_In;
        if (Valid_In) begin
          we    = 1'b1;
          wdata = sat_sum;
        end
        // The weight write lands on the same edge the scan starts, so the
        // scan reads the updated value.
        if (Step_In) begin
          state_nx = ST_SCAN;
          idx_nx   = '0;
        end
      end
      ST_SCAN: begin
        if (fire) begin
          state_nx       = ST_EMIT;
          spike_valid_nx = 1'b1;
          spike_id_nx    = idx;
        end else begin
          we    = 1'b1;
          wdata = leaked;
          if (last) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (Spike_Ready) begin
          we             = 1'b1;
          wdata          = '0;
          spike_valid_nx = 1'b0;
          if (last) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
          end else begin
            state_nx = ST_SCAN;
            idx_nx   = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      spike_valid <= spike_valid_nx;
      spike_id    <= spike_id_nx;
    end
  end

  assign Spike_Valid = spike_valid;
  assign Spike_ID    = spike_id;
  assign Busy        = (state != ST_IDLE);

endmodule
